decoder_scan_ctrl: RTL and testbench
====================================

// Module: decoder_scan_ctrl
// PURPOSE
//   Upstream sequencer for the 3-to-8 active-low decoder stage. Steps a channel
//   address across the enabled channels of an 8-bit mask and drives the address
//   (A2..A0) and enable (E1_n, E2_n, E3) inputs of that decoder. Each channel is
//   held active for a programmable dwell, with blanking cycles between channels.
//   Supports single-pass and continuous scanning.
// PARAMETERS
//   DWELL_W    8  width of dwell input; active window = max(dwell,1) cycles
//   GUARD_CYC  1  blanking cycles (decoder disabled) before each window; legal range 1..15
// PORTS
//   clk       in   1        single clock; all logic on rising edge
//   rst_n     in   1        asynchronous, active-low reset
//   start     in   1        1-cycle request to begin a scan; honoured only in IDLE
//   stop      in   1        abort; honoured in any non-IDLE state
//   mode      in   1        0 = single pass, 1 = continuous; sampled with start
//   ch_mask   in   8        bit i = 1 enables channel i; sampled with start
//   dwell     in   DWELL_W  active cycles per channel; sampled with start
//   A0,A1,A2  out  1 each   channel address to decoder (A2 = MSB), registered
//   E1_n      out  1        decoder enable, active low, registered
//   E2_n      out  1        decoder enable, active low, registered
//   E3        out  1        decoder enable, active high, registered
//   busy      out  1        1 in any state except IDLE
//   ch_strobe out  1        1-cycle pulse on the first ACTIVE cycle of each window
//   pass_done out  1        1-cycle pulse after the last window of a pass completes
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     A=0, E1_n=1, E2_n=1, E3=0, busy=0, ch_strobe=0, pass_done=0.
//     State = IDLE; guard and dwell counters = 0.
//   Enable encoding: ACTIVE drives {E3,E2_n,E1_n}=3'b100; every other state drives 3'b011.
//   States:
//     IDLE: decoder disabled; A holds its last value.
//       - start=1, stop=0, ch_mask!=0: latch mode/mask/dwell. Next cycle enter
//         GUARD, with A = lowest set mask bit.
//       - start with ch_mask==0: ignored.
//       - start and stop both high: stop wins; remain IDLE.
//     GUARD: decoder disabled for exactly GUARD_CYC cycles, then enter ACTIVE.
//     ACTIVE: decoder enabled for exactly max(dwell,1) cycles; ch_strobe on the first.
//       On exit, next channel = next set bit strictly above current A, wrapping to
//       the lowest set bit.
//       - If the wrap occurred (including a single-channel mask), the channel just
//         served was the last of the pass:
//           pass_done=1 in the next cycle;
//           mode=0: enter IDLE;
//           mode=1: enter GUARD with A = next channel.
//       - Otherwise enter GUARD with A = next channel.
//   A changes only on entry to GUARD. It is stable through GUARD and ACTIVE, so the
//   decoder never sees an address change while enabled.
//   stop=1 in GUARD/ACTIVE: next cycle IDLE, decoder disabled, no pass_done.
//   A start received while busy is ignored; a new mask takes effect only from IDLE.
//   Throughput: each window costs GUARD_CYC + max(dwell,1) cycles.
//   Reset mid-scan: outputs return to reset values immediately (asynchronous).
// TESTING
//   T1 Reset: rst_n low mid-ACTIVE -> outputs at reset values with no clock edge; IDLE after release.
//   T2 Single pass: mask=8'h05, dwell=3, GUARD_CYC=1, start at edge 0 ->
//        c1 GUARD A=0; c2-4 ACTIVE A=0 (strobe c2); c5 GUARD A=2;
//        c6-8 ACTIVE A=2 (strobe c6); c9 IDLE with pass_done=1, busy=0.
//   T3 Continuous: mask=8'h80, dwell=0, mode=1 -> A=7 always; ACTIVE 1 cycle of every 2;
//        pass_done one cycle after each window; wrap 7->7 correct.
//   T4 Abort: stop asserted in the 2nd ACTIVE cycle of channel 3 -> next cycle
//        {E3,E2_n,E1_n}=011, busy=0, no pass_done; a following start restarts at the lowest channel.
//   T5 Ignored requests: start with mask=0 -> stays IDLE.
//        start+stop together -> stays IDLE.
//        start while busy -> scan unchanged.
//   T6 Full mask, mode=1, 3 passes -> A sequence 0..7 repeated; exactly 3 pass_done pulses;
//        enables never asserted while A changes (checker on decoder inputs).

Source files
------------

// File: rtl/decoder_scan_ctrl_if.sv
// Control and decoder-drive signals between a scan requester and decoder_scan_ctrl.
// The master drives the scan requests. The slave drives the decoder address, the enables and the status.
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [7:0]         ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic               A0;
    logic               A1;
    logic               A2;
    logic               E1_n;
    logic               E2_n;
    logic               E3;
    logic               busy;
    logic               ch_strobe;
    logic               pass_done;

    modport master (
        output start, stop, mode, ch_mask, dwell,
        input  A0, A1, A2, E1_n, E2_n, E3, busy, ch_strobe, pass_done
    );

    modport slave (
        input  start, stop, mode, ch_mask, dwell,
        output A0, A1, A2, E1_n, E2_n, E3, busy, ch_strobe, pass_done
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3-to-8 active-low decoder. It steps through the enabled channels and
// gives each one a guard period followed by a dwell window.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | decoder disabled, A holds, waiting for start
//   S_GUARD  | decoder disabled for GUARD_CYC cycles, A already settled
//   S_ACTIVE | decoder enabled for max(dwell,1) cycles on channel A
module decoder_scan_ctrl #(
    parameter int DWELL_W   = 8,
    parameter int GUARD_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_scan_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GUARD  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYC - 1);

    state_t             state_q, state_d;
    logic [2:0]         a_q, a_d;
    logic [7:0]         mask_q, mask_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] dlen_q, dlen_d;
    logic [3:0]         gcnt_q, gcnt_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic               act_q, act_d;
    logic               strobe_q, strobe_d;
    logic               pd_q, pd_d;
    logic               busy_q, busy_d;

    logic [7:0]         above;
    logic               wrap;
    logic [2:0]         nxt_ch;
    logic               win_end;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Channels strictly above the current one. If none are left, the scan wraps to the lowest channel.
    assign above   = mask_q & (8'hFE << a_q);
    assign wrap    = (above == 8'h00);
    assign nxt_ch  = wrap ? lowest_set(mask_q) : lowest_set(above);
    assign win_end = (state_q == S_ACTIVE) && !bus.stop && (dcnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            mask_q   <= '0;
            mode_q   <= 1'b0;
            dlen_q   <= '0;
            gcnt_q   <= '0;
            dcnt_q   <= '0;
            act_q    <= 1'b0;
            strobe_q <= 1'b0;
            pd_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            dlen_q   <= dlen_d;
            gcnt_q   <= gcnt_d;
            dcnt_q   <= dcnt_d;
            act_q    <= act_d;
            strobe_q <= strobe_d;
            pd_q     <= pd_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        dlen_d  = dlen_q;
        gcnt_d  = gcnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop && (bus.ch_mask != 8'h00)) begin
                    state_d = S_GUARD;
                    a_d     = lowest_set(bus.ch_mask);
                    mask_d  = bus.ch_mask;
                    mode_d  = bus.mode;
                    dlen_d  = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
                    gcnt_d  = GUARD_LOAD;
                end
            end
            S_GUARD: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    gcnt_d  = '0;
                end else if (gcnt_q == '0) begin
                    state_d = S_ACTIVE;
                    dcnt_d  = dlen_q;
                end else begin
                    gcnt_d  = gcnt_q - 4'd1;
                end
            end
            S_ACTIVE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == '0) begin
                    if (wrap && !mode_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GUARD;
                        a_d     = nxt_ch;
                        gcnt_d  = GUARD_LOAD;
                    end
                end else begin
                    dcnt_d  = dcnt_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        act_d    = (state_d == S_ACTIVE);
        strobe_d = (state_d == S_ACTIVE) && (state_q != S_ACTIVE);
        pd_d     = win_end && wrap;
        busy_d   = (state_d != S_IDLE);
    end

    assign bus.A0        = a_q[0];
    assign bus.A1        = a_q[1];
    assign bus.A2        = a_q[2];
    assign bus.E3        = act_q;
    assign bus.E2_n      = ~act_q;
    assign bus.E1_n      = ~act_q;
    assign bus.busy      = busy_q;
    assign bus.ch_strobe = strobe_q;
    assign bus.pass_done = pd_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl. It predicts the decoder inputs and status cycle by cycle
// from the scan request, queues the predictions, and compares them against the DUT one cycle at a time.
module tb_decoder_scan_ctrl;
    localparam int DWELL_W   = 8;
    localparam int GUARD_CYC = 1;

    typedef logic [8:0] vec_t;
    localparam vec_t RESET_VEC = 9'b000_011_000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

    decoder_scan_ctrl #(.DWELL_W(DWELL_W), .GUARD_CYC(GUARD_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] last_a = 3'd0;
    int         pd_count = 0;
    int         viol = 0;
    logic [2:0] mon_prev_a = 3'd0;

    // vector layout: {A2,A1,A0, E3,E2_n,E1_n, busy, ch_strobe, pass_done}
    function automatic vec_t obs();
        return {bus.A2, bus.A1, bus.A0, bus.E3, bus.E2_n, bus.E1_n,
                bus.busy, bus.ch_strobe, bus.pass_done};
    endfunction

    function automatic void push_cyc(logic [2:0] a, logic act, logic bsy, logic strb, logic pd);
        q.push_back({a, act, ~act, ~act, bsy, strb, pd});
        last_a = a;
    endfunction

    function automatic void push_idle(logic pd);
        push_cyc(last_a, 1'b0, 1'b0, 1'b0, pd);
    endfunction

    function automatic void push_window(logic [2:0] ch, int dw, logic pd_first);
        int n;
        n = (dw == 0) ? 1 : dw;
        for (int g = 0; g < GUARD_CYC; g++) push_cyc(ch, 1'b0, 1'b1, 1'b0, (g == 0) ? pd_first : 1'b0);
        for (int k = 0; k < n; k++) push_cyc(ch, 1'b1, 1'b1, (k == 0), 1'b0);
    endfunction

    function automatic void gen_scan(logic [7:0] mask, int dw, int passes, logic cont);
        logic pd;
        pd = 1'b0;
        for (int p = 0; p < passes; p++) begin
            for (int ch = 0; ch < 8; ch++) begin
                if (mask[ch]) begin
                    push_window(3'(ch), dw, pd);
                    pd = 1'b0;
                end
            end
            pd = 1'b1;
        end
        if (!cont) push_idle(1'b1);
    endfunction

    task automatic kick(logic [7:0] mask, logic [DWELL_W-1:0] dw, logic md);
        bus.start   = 1'b1;
        bus.ch_mask = mask;
        bus.dwell   = dw;
        bus.mode    = md;
    endtask

    // Decoder-input checker: the address must never change while the decoder is enabled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.E3 && ({bus.A2, bus.A1, bus.A0} != mon_prev_a)) viol++;
            mon_prev_a = {bus.A2, bus.A1, bus.A0};
        end
    end

    task automatic test_reset();
        vec_t e;
        rst_n = 1'b0;
        #12;
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", obs(), RESET_VEC);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_a = 3'd0;
        push_idle(1'b0);
        push_idle(1'b0);
        while (q.size() > 0) begin
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset_idle got %b exp %b", obs(), e);
            end
        end
    endtask

    task automatic test_single_pass();
        vec_t e;
        int n;
        n = 1;
        kick(8'h05, 8'd3, 1'b0);
        gen_scan(8'h05, 3, 1, 1'b0);
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL single_pass c%0d got %b exp %b", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_continuous();
        vec_t e;
        int n;
        n = 1;
        kick(8'h80, 8'd0, 1'b1);
        gen_scan(8'h80, 0, 3, 1'b1);
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL continuous c%0d got %b exp %b", n, obs(), e);
            end
            n++;
        end
        bus.stop = 1'b1;
        push_idle(1'b0);
        @(posedge clk); #1;
        bus.stop = 1'b0;
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL continuous_stop got %b exp %b", obs(), e);
        end
    endtask

    task automatic test_abort();
        vec_t e;
        int n;
        n = 1;
        kick(8'h0A, 8'd4, 1'b0);
        push_window(3'd1, 4, 1'b0);
        push_cyc(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        push_cyc(3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        push_cyc(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL abort_trace c%0d got %b exp %b", n, obs(), e);
            end
            n++;
        end
        // still in the 2nd active cycle of channel 3
        bus.stop = 1'b1;
        push_idle(1'b0);
        push_idle(1'b0);
        kick(8'h0A, 8'd4, 1'b0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abort_idle got %b exp %b", obs(), e);
        end
        @(posedge clk); #1;
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abort_hold got %b exp %b", obs(), e);
        end
        kick(8'h0A, 8'd4, 1'b0);
        push_window(3'd1, 4, 1'b0);
        n = 1;
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL abort_restart c%0d got %b exp %b", n, obs(), e);
            end
            n++;
        end
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        push_idle(1'b0);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abort_restart_stop got %b exp %b", obs(), e);
        end
    endtask

    task automatic test_ignored();
        vec_t e;
        int n;
        kick(8'h00, 8'd3, 1'b0);
        push_idle(1'b0); push_idle(1'b0); push_idle(1'b0);
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL ignore_zero_mask got %b exp %b", obs(), e);
            end
        end
        kick(8'h05, 8'd3, 1'b0);
        bus.stop = 1'b1;
        push_idle(1'b0); push_idle(1'b0); push_idle(1'b0);
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL ignore_start_stop got %b exp %b", obs(), e);
            end
        end
        kick(8'h05, 8'd2, 1'b0);
        gen_scan(8'h05, 2, 1, 1'b0);
        n = 1;
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            if (n == 2) kick(8'hFF, 8'd7, 1'b1);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL ignore_busy_start c%0d got %b exp %b", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_full_mask();
        vec_t e;
        int n;
        n = 1;
        pd_count = 0;
        kick(8'hFF, 8'd2, 1'b1);
        gen_scan(8'hFF, 2, 3, 1'b1);
        push_cyc(3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            if (bus.pass_done) pd_count++;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL full_mask c%0d got %b exp %b", n, obs(), e);
            end
            n++;
        end
        bus.stop = 1'b1;
        push_idle(1'b0);
        @(posedge clk); #1;
        bus.stop = 1'b0;
        if (bus.pass_done) pd_count++;
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL full_mask_stop got %b exp %b", obs(), e);
        end
        checks++;
        if (pd_count !== 3) begin
            errors++;
            $display("FAIL pass_done_count got %0d exp 3", pd_count);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL addr_change_while_enabled got %0d exp 0", viol);
        end
    endtask

    task automatic test_async_reset();
        vec_t e;
        kick(8'h08, 8'd5, 1'b0);
        push_cyc(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        push_cyc(3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        push_cyc(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.stop = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL async_reset_pre got %b exp %b", obs(), e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_immediate got %b exp %b", obs(), RESET_VEC);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_a = 3'd0;
        @(posedge clk); #1;
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_release got %b exp %b", obs(), RESET_VEC);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.mode    = 1'b0;
        bus.ch_mask = 8'h00;
        bus.dwell   = '0;
        test_reset();
        test_single_pass();
        test_continuous();
        test_abort();
        test_ignored();
        test_full_mask();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
